// File: rtl/seg_anim_ctrl.sv
// Value register and spinner/flash animation sequencer feeding the seven-segment decoder.
// All outputs are registered; anim_stop_in aborts from any state with the highest priority.
module seg_anim_ctrl #(
    parameter int TICK_DIV   = 50000,
    parameter int ANIM_LOOPS = 2
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       wr_en_in,
    input  logic [4:0] wr_data_in,
    input  logic       anim_start_in,
    input  logic       anim_stop_in,
    output logic [4:0] value_out,
    output logic [7:0] bit_array_out,
    output logic       anim_en_out,
    output logic       busy_out
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int LOOP_W = (ANIM_LOOPS > 0) ? $clog2(ANIM_LOOPS + 1) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'(ANIM_LOOPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SPIN,
        ST_FLASH
    } state_t;

    state_t            state;
    logic [TICK_W-1:0] tick;
    logic [2:0]        step;
    logic [LOOP_W-1:0] loop_cnt;

    // The processor's value is independent of the animation and is written in any state.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            value_out <= 5'h00;
        end else if (wr_en_in) begin
            value_out <= wr_data_in;
        end
    end

    // NOTE: every register here, outputs included, uses <= so all of them see the
    // pre-edge values of each other; blocking updates would make the order of
    // statements change the hardware.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= ST_IDLE;
            tick          <= '0;
            step          <= 3'd0;
            loop_cnt      <= '0;
            bit_array_out <= 8'h00;
            anim_en_out   <= 1'b0;
            busy_out      <= 1'b0;
        end else if (anim_stop_in) begin
            state         <= ST_IDLE;
            tick          <= '0;
            step          <= 3'd0;
            loop_cnt      <= '0;
            bit_array_out <= 8'h00;
            anim_en_out   <= 1'b0;
            busy_out      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tick     <= '0;
                    step     <= 3'd0;
                    loop_cnt <= '0;
                    if (anim_start_in) begin
                        state         <= ST_SPIN;
                        bit_array_out <= 8'h01;
                        anim_en_out   <= 1'b1;
                        busy_out      <= 1'b1;
                    end
                end

                ST_SPIN: begin
                    if (tick == TICK_LAST) begin
                        tick <= '0;
                        if (step == 3'd5) begin
                            step     <= 3'd0;
                            loop_cnt <= loop_cnt + LOOP_W'(1);
                            if (loop_cnt == LOOP_LAST) begin
                                state         <= ST_FLASH;
                                bit_array_out <= 8'hFF;
                            end else begin
                                bit_array_out <= 8'h01;
                            end
                        end else begin
                            step          <= step + 3'd1;
                            bit_array_out <= 8'h01 << (step + 3'd1);
                        end
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end

                ST_FLASH: begin
                    if (tick == TICK_LAST) begin
                        state         <= ST_IDLE;
                        tick          <= '0;
                        step          <= 3'd0;
                        loop_cnt      <= '0;
                        bit_array_out <= 8'h00;
                        anim_en_out   <= 1'b0;
                        busy_out      <= 1'b0;
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end

                default: begin
                    state         <= ST_IDLE;
                    tick          <= '0;
                    step          <= 3'd0;
                    loop_cnt      <= '0;
                    bit_array_out <= 8'h00;
                    anim_en_out   <= 1'b0;
                    busy_out      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/seg_anim_ctrl.md
# seg_anim_ctrl

Register-and-sequencer stage directly upstream of the seven-segment decoder. It holds the 5-bit value written by the processor and drives it to the decoder. On request it runs a timed "spinner" animation, rotating a single lit outer segment, followed by a one-step all-on flash. During the animation it drives the decoder's raw bit-array path and animation-enable. All outputs are registered and connect straight to the decoder's `value_in`, `bit_array_in` and `anim_en_in`.

## Interface
- `TICK_DIV`, 50000: clock cycles each animation pattern is held; legal range ≥1.
- `ANIM_LOOPS`, 2: number of full 6-step rotations before the flash; legal range ≥1.

- `clk_in`  in  1  system clock; all state updates on the rising edge.
- `rst_n_in`  in  1  reset; asynchronous, active-low.
- `wr_en_in`  in  1  loads `wr_data_in` into the value register.
- `wr_data_in`  in  5  value to display; bit 4 is the decimal point, bits 3:0 are the hex digit.
- `anim_start_in`  in  1  level, sampled in IDLE only; starts the animation.
- `anim_stop_in`  in  1  aborts the animation; sampled in every state.
- `value_out`  out  5  held display value; goes to the decoder's `value_in`.
- `bit_array_out`  out  8  raw segment pattern (bit0 = segment 1 … bit6 = segment 7, bit7 = dp).
- `anim_en_out`  out  1  high while SPIN or FLASH is active.
- `busy_out`  out  1  high whenever state ≠ IDLE.

## Operation
- Value register:
  - `wr_en_in` = 1 loads `wr_data_in` into `value_out` at the next edge, in any state.
  - The value is not modified by the animation and is displayed again once the animation ends.
- FSM states:
  - **IDLE**: `anim_en_out`=0, `bit_array_out`=8'h00.
  - **SPIN**: patterns 8'h01, 02, 04, 08, 10, 20 in order (segments 1→6, clockwise). The sequence repeats `ANIM_LOOPS` times.
  - **FLASH**: pattern 8'hFF for one step, then return to IDLE.
- Transitions:
  - IDLE→SPIN when `anim_start_in`=1 and `anim_stop_in`=0.
  - SPIN→FLASH after the 20 pattern of the last loop completes its step.
  - FLASH→IDLE after one step.
  - Any state→IDLE when `anim_stop_in`=1 (highest priority).
- Counters:
  - The tick counter counts 0..`TICK_DIV`-1. It is cleared on entry to SPIN, on every step advance, and on IDLE. Width is max(1, clog2(`TICK_DIV`)).
  - A step advances when tick = `TICK_DIV`-1.
  - The step index counts 0..5 and wraps to 0. The loop counter increments on each wrap. Loop-counter width is max(1, clog2(`ANIM_LOOPS`+1)).
- Boundary rules:
  - `anim_start_in` while busy: ignored, no restart.
  - `anim_start_in` and `anim_stop_in` both high in IDLE: stay in IDLE.
  - `wr_en_in` and `anim_start_in` in the same cycle: both take effect.
  - `TICK_DIV`=1: patterns advance every cycle.
  - Asynchronous reset mid-animation: immediately returns to reset values.

## Timing
- Reset values:
  - Outputs: `value_out`=5'h00, `bit_array_out`=8'h00, `anim_en_out`=0, `busy_out`=0.
  - Internal: state=IDLE, all counters 0.
- Write latency: `value_out` updates 1 cycle after the edge that samples `wr_en_in`.
- Start latency: at the edge sampling a valid start, `busy_out`=1, `anim_en_out`=1 and `bit_array_out`=8'h01 are all set.
- Step timing:
  - Each pattern is held exactly `TICK_DIV` cycles.
  - Total busy time is (6·`ANIM_LOOPS`+1)·`TICK_DIV` cycles.
- End: at the edge after the FLASH step ends, state=IDLE, `anim_en_out`=0, `bit_array_out`=8'h00, `busy_out`=0.
- Stop latency: 1 edge to IDLE outputs. The tick and step counters clear on that same edge.

## Test plan
1. **Reset and write**
   - Stimulus: release reset, then write 5'h1A.
   - Required: all outputs are 0 while in reset; `value_out`=5'h1A one cycle after the write; `anim_en_out` stays 0.
2. **Full animation**
   - Stimulus: `TICK_DIV`=4, `ANIM_LOOPS`=2; pulse start.
   - Required: `bit_array_out` sequence is 01,02,04,08,10,20 ×2, then FF, each value held 4 cycles.
   - Required: `busy_out` high for exactly 52 cycles, then returns to IDLE with 8'h00.
3. **Abort**
   - Stimulus: assert `anim_stop_in` during the third step of SPIN.
   - Required: next cycle `busy_out`=0, `anim_en_out`=0, `bit_array_out`=00.
   - Required: a later start begins again at 8'h01 with a full 4-cycle hold.
4. **Collisions**
   - Stimulus: assert start and stop together in IDLE.
   - Required: stays in IDLE.
   - Stimulus: assert start again while busy.
   - Required: the total still completes in 52 cycles.
   - Stimulus: write 5'h07 during SPIN.
   - Required: `value_out`=5'h07 one cycle later while `bit_array_out` continues its sequence unaffected.
5. **TICK_DIV=1**
   - Stimulus: `TICK_DIV`=1, `ANIM_LOOPS`=1; pulse start.
   - Required: the pattern changes every cycle, 7 busy cycles total.
6. **Asynchronous reset mid-FLASH**
   - Stimulus: drive `rst_n_in` low between clock edges during FLASH.
   - Required: outputs go to 0 without waiting for a clock edge.
   - Required: `value_out` also clears to 5'h00.
